// File: rtl/sc_counter_mod_pkg.sv
// sc_counter_mod_pkg: shared constants for the modulo counter family.
//   dir_e  - count direction encoding as seen on the UP input.
//   mode_e - boundary behaviour (wrap or saturate).
//   clog2  - ceiling log2 usable in parameter expressions.
package sc_counter_mod_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sc_counter_mod_if.sv
// sc_counter_mod_if: control/status bundle of the modulo counter.
//   ENABLE_InLow, CLEAR_InLow, LOAD_InLow, LOADVALUE[N], UP : controller -> counter
//   REGCOUNT[N], TC_OutLow, COMPARE_OutLow                  : counter -> controller
// Modports: master = controller side, slave = counter side.
interface sc_counter_mod_if #(
  parameter int unsigned N = 8
);
  logic         SC_COUNTERMOD_ENABLE_InLow;
  logic         SC_COUNTERMOD_CLEAR_InLow;
  logic         SC_COUNTERMOD_LOAD_InLow;
  logic [N-1:0] SC_COUNTERMOD_LOADVALUE;
  logic         SC_COUNTERMOD_UP;
  logic [N-1:0] SC_COUNTERMOD_REGCOUNT;
  logic         SC_COUNTERMOD_TC_OutLow;
  logic         SC_COUNTERMOD_COMPARE_OutLow;

  modport master (
    output SC_COUNTERMOD_ENABLE_InLow, SC_COUNTERMOD_CLEAR_InLow,
           SC_COUNTERMOD_LOAD_InLow, SC_COUNTERMOD_LOADVALUE, SC_COUNTERMOD_UP,
    input  SC_COUNTERMOD_REGCOUNT, SC_COUNTERMOD_TC_OutLow,
           SC_COUNTERMOD_COMPARE_OutLow
  );

  modport slave (
    input  SC_COUNTERMOD_ENABLE_InLow, SC_COUNTERMOD_CLEAR_InLow,
           SC_COUNTERMOD_LOAD_InLow, SC_COUNTERMOD_LOADVALUE, SC_COUNTERMOD_UP,
    output SC_COUNTERMOD_REGCOUNT, SC_COUNTERMOD_TC_OutLow,
           SC_COUNTERMOD_COMPARE_OutLow
  );
endinterface

// File: rtl/sc_counter_mod_prescaler.sv
// sc_prescaler: divides enabled clock cycles down to one tick every PRESCALE.
//   clk      : system clock (rising edge)
//   rst      : synchronous active-high reset
//   enable_n : low = advance the prescaler
//   clear    : high = return the prescaler to 0 (no tick)
//   tick     : high in the enabled cycle in which the prescaler is at PRESCALE-1
module sc_prescaler
  import sc_counter_mod_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (clear) begin
      pre_d = '0;
    end else if (!enable_n) begin
      if (pre_q == LAST) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/sc_counter_mod.sv
// sc_counter_mod: parametrised up/down modulo counter with load, clear,
// wrap/saturate mode, prescaled stepping, terminal-count pulse and compare flag.
//   SC_COUNTERMOD_CLOCK        : system clock (rising edge)
//   SC_COUNTERMOD_RESET_InHigh : synchronous active-high reset
//   bus (slave)                : enable/clear/load/loadvalue/up in,
//                                regcount/tc/compare out
module sc_counter_mod
  import sc_counter_mod_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MODULO   = 250,
  parameter int unsigned COMPARE  = 125,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic              SC_COUNTERMOD_CLOCK,
  input  logic              SC_COUNTERMOD_RESET_InHigh,
  sc_counter_mod_if.slave   bus
);

  if (MODULO < 2 || 64'(MODULO) > (64'(1) << N)) begin : g_bad_modulo
    $error("sc_counter_mod: MODULO out of range 2..2^N");
  end
  if (COMPARE >= MODULO) begin : g_bad_compare
    $error("sc_counter_mod: COMPARE must be below MODULO");
  end
  if (PRESCALE == 0) begin : g_bad_prescale
    $error("sc_counter_mod: PRESCALE must be at least 1");
  end

  localparam mode_e          MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
  localparam logic [N:0]     MOD_EXT = (N+1)'(MODULO);
  localparam logic [N-1:0]   MAX_VAL = N'(MODULO - 1);
  localparam logic [N-1:0]   CMP_VAL = N'(COMPARE);

  logic [N-1:0] count_q, count_d;
  logic         tc_n_q, tc_n_d;
  logic         tick;
  logic         pre_clear;
  logic [N:0]   next_ext;
  logic         at_boundary;

  assign pre_clear = ~(bus.SC_COUNTERMOD_CLEAR_InLow & bus.SC_COUNTERMOD_LOAD_InLow);

  sc_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (SC_COUNTERMOD_CLOCK),
    .rst      (SC_COUNTERMOD_RESET_InHigh),
    .enable_n (bus.SC_COUNTERMOD_ENABLE_InLow),
    .clear    (pre_clear),
    .tick     (tick)
  );

  // One extra bit: stepping up past MODULO-1 lands exactly on MODULO (even when
  // MODULO = 2^N), and stepping down from 0 borrows into bit N.
  always_comb begin
    if (bus.SC_COUNTERMOD_UP == DIR_UP) begin
      next_ext    = {1'b0, count_q} + (N+1)'(1);
      at_boundary = (next_ext == MOD_EXT);
    end else begin
      next_ext    = {1'b0, count_q} - (N+1)'(1);
      at_boundary = next_ext[N];
    end
  end

  always_comb begin
    count_d = count_q;
    tc_n_d  = 1'b1;
    if (!bus.SC_COUNTERMOD_CLEAR_InLow) begin
      count_d = '0;
    end else if (!bus.SC_COUNTERMOD_LOAD_InLow) begin
      if ({1'b0, bus.SC_COUNTERMOD_LOADVALUE} >= MOD_EXT) count_d = MAX_VAL;
      else                                                count_d = bus.SC_COUNTERMOD_LOADVALUE;
    end else if (tick) begin
      if (at_boundary) begin
        tc_n_d = 1'b0;
        if (MODE == MODE_SAT)                     count_d = count_q;
        else if (bus.SC_COUNTERMOD_UP == DIR_UP)  count_d = '0;
        else                                      count_d = MAX_VAL;
      end else begin
        count_d = next_ext[N-1:0];
      end
    end
  end

  always_ff @(posedge SC_COUNTERMOD_CLOCK) begin
    if (SC_COUNTERMOD_RESET_InHigh) begin
      count_q <= '0;
      tc_n_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_n_q  <= tc_n_d;
    end
  end

  assign bus.SC_COUNTERMOD_REGCOUNT       = count_q;
  assign bus.SC_COUNTERMOD_TC_OutLow      = tc_n_q;
  assign bus.SC_COUNTERMOD_COMPARE_OutLow = (count_q != CMP_VAL);

endmodule

// File: tb/tb_sc_counter_mod.sv
// Bench for sc_counter_mod. Four instances share one stimulus stream:
//   d0 defaults, d1 saturating, d2 PRESCALE=4, d3 MODULO=256.
module tb_sc_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_n = 1'b1, clr_n = 1'b1, ld_n = 1'b1, up = 1'b1;
  logic [7:0] lv = '0;

  always #5 clk = ~clk;

  sc_counter_mod_if #(.N(8)) if0 ();
  sc_counter_mod_if #(.N(8)) if1 ();
  sc_counter_mod_if #(.N(8)) if2 ();
  sc_counter_mod_if #(.N(8)) if3 ();

  assign if0.SC_COUNTERMOD_ENABLE_InLow = en_n;
  assign if0.SC_COUNTERMOD_CLEAR_InLow  = clr_n;
  assign if0.SC_COUNTERMOD_LOAD_InLow   = ld_n;
  assign if0.SC_COUNTERMOD_LOADVALUE    = lv;
  assign if0.SC_COUNTERMOD_UP           = up;
  assign if1.SC_COUNTERMOD_ENABLE_InLow = en_n;
  assign if1.SC_COUNTERMOD_CLEAR_InLow  = clr_n;
  assign if1.SC_COUNTERMOD_LOAD_InLow   = ld_n;
  assign if1.SC_COUNTERMOD_LOADVALUE    = lv;
  assign if1.SC_COUNTERMOD_UP           = up;
  assign if2.SC_COUNTERMOD_ENABLE_InLow = en_n;
  assign if2.SC_COUNTERMOD_CLEAR_InLow  = clr_n;
  assign if2.SC_COUNTERMOD_LOAD_InLow   = ld_n;
  assign if2.SC_COUNTERMOD_LOADVALUE    = lv;
  assign if2.SC_COUNTERMOD_UP           = up;
  assign if3.SC_COUNTERMOD_ENABLE_InLow = en_n;
  assign if3.SC_COUNTERMOD_CLEAR_InLow  = clr_n;
  assign if3.SC_COUNTERMOD_LOAD_InLow   = ld_n;
  assign if3.SC_COUNTERMOD_LOADVALUE    = lv;
  assign if3.SC_COUNTERMOD_UP           = up;

  sc_counter_mod #(.N(8)) d0 (
    .SC_COUNTERMOD_CLOCK(clk), .SC_COUNTERMOD_RESET_InHigh(rst), .bus(if0));
  sc_counter_mod #(.N(8), .SATURATE(1)) d1 (
    .SC_COUNTERMOD_CLOCK(clk), .SC_COUNTERMOD_RESET_InHigh(rst), .bus(if1));
  sc_counter_mod #(.N(8), .PRESCALE(4)) d2 (
    .SC_COUNTERMOD_CLOCK(clk), .SC_COUNTERMOD_RESET_InHigh(rst), .bus(if2));
  sc_counter_mod #(.N(8), .MODULO(256)) d3 (
    .SC_COUNTERMOD_CLOCK(clk), .SC_COUNTERMOD_RESET_InHigh(rst), .bus(if3));

  logic [7:0] o_cnt [4];
  logic       o_tc  [4];
  logic       o_cmp [4];
  assign o_cnt[0] = if0.SC_COUNTERMOD_REGCOUNT;
  assign o_cnt[1] = if1.SC_COUNTERMOD_REGCOUNT;
  assign o_cnt[2] = if2.SC_COUNTERMOD_REGCOUNT;
  assign o_cnt[3] = if3.SC_COUNTERMOD_REGCOUNT;
  assign o_tc[0]  = if0.SC_COUNTERMOD_TC_OutLow;
  assign o_tc[1]  = if1.SC_COUNTERMOD_TC_OutLow;
  assign o_tc[2]  = if2.SC_COUNTERMOD_TC_OutLow;
  assign o_tc[3]  = if3.SC_COUNTERMOD_TC_OutLow;
  assign o_cmp[0] = if0.SC_COUNTERMOD_COMPARE_OutLow;
  assign o_cmp[1] = if1.SC_COUNTERMOD_COMPARE_OutLow;
  assign o_cmp[2] = if2.SC_COUNTERMOD_COMPARE_OutLow;
  assign o_cmp[3] = if3.SC_COUNTERMOD_COMPARE_OutLow;

  // Reference model configuration and state, one slot per instance.
  int P_MOD [4] = '{250, 250, 250, 256};
  int P_CMP [4] = '{125, 125, 125, 125};
  int P_SAT [4] = '{0, 1, 0, 0};
  int P_PRE [4] = '{1, 1, 4, 1};
  int m_cnt [4];
  int m_pre [4];
  int m_tc  [4];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s d%0d: got %0d expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // Counter behaviour expressed as plain integer arithmetic on the range 0..MODULO-1.
  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      int n;
      bit tk;
      m_tc[k] = 1;
      if (rst || !clr_n) begin
        m_cnt[k] = 0;
        m_pre[k] = 0;
      end else if (!ld_n) begin
        m_cnt[k] = (int'(lv) >= P_MOD[k]) ? P_MOD[k] - 1 : int'(lv);
        m_pre[k] = 0;
      end else if (!en_n) begin
        m_pre[k] = (m_pre[k] + 1) % P_PRE[k];
        tk = (m_pre[k] == 0);
        if (tk) begin
          n = m_cnt[k] + (up ? 1 : -1);
          if (n < 0 || n >= P_MOD[k]) begin
            m_tc[k] = 0;
            if (P_SAT[k] == 0) m_cnt[k] = (n + P_MOD[k]) % P_MOD[k];
          end else begin
            m_cnt[k] = n;
          end
        end
      end
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic c, input logic l,
                       input logic [7:0] v, input logic u);
    rst = r; en_n = e; clr_n = c; ld_n = l; lv = v; up = u;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("model_cnt", k, int'(o_cnt[k]), m_cnt[k]);
      chk("model_tc",  k, int'(o_tc[k]),  m_tc[k]);
      chk("model_cmp", k, int'(o_cmp[k]), (m_cnt[k] == P_CMP[k]) ? 0 : 1);
    end
  endtask

  typedef struct {
    logic       r, e, c, l;
    logic [7:0] v;
    logic       u;
    int         e_cnt;
    logic       e_tc, e_cmp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Expected values for the default instance d0 (MODULO 250, COMPARE 125, wrap).
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0,   1'b1, 0,   1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd100, 1'b1, 100, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 249, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 0,   1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 1,   1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   1'b1, 1,   1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd124, 1'b1, 124, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 125, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   1'b1, 125, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 124, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd50,  1'b0, 0,   1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 249, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 248, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd200, 1'b1, 200, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 0,   1'b1, 1'b1};

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].v, tbl[i].u);
      chk("tbl_cnt", 0, int'(o_cnt[0]), tbl[i].e_cnt);
      chk("tbl_tc",  0, int'(o_tc[0]),  int'(tbl[i].e_tc));
      chk("tbl_cmp", 0, int'(o_cmp[0]), int'(tbl[i].e_cmp));
    end

    // Full up-count cycle on d0: wrap after 250 steps, compare only at 125.
    apply(1, 1, 1, 1, 0, 1);
    for (int i = 1; i <= 251; i++) begin
      apply(0, 0, 1, 1, 0, 1);
      if (i == 125) chk("cmp_at_125", 0, int'(o_cmp[0]), 0);
      if (i == 250) begin
        chk("wrap_cnt", 0, int'(o_cnt[0]), 0);
        chk("wrap_tc",  0, int'(o_tc[0]),  0);
      end
    end

    // Down from reset: d0 wraps to 249 then 248; d1 saturates at 0 and pulses each tick.
    apply(1, 1, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      apply(0, 0, 1, 1, 0, 0);
      chk("sat_cnt", 1, int'(o_cnt[1]), 0);
      chk("sat_tc",  1, int'(o_tc[1]),  0);
      if (i == 1) chk("down_first", 0, int'(o_cnt[0]), 249);
      if (i == 2) chk("down_second", 0, int'(o_cnt[0]), 248);
    end

    // Prescale 4 on d2: steps on enabled cycles 4, 8, 12.
    apply(1, 1, 1, 1, 0, 1);
    for (int i = 1; i <= 12; i++) begin
      apply(0, 0, 1, 1, 0, 1);
      if (i == 3)  chk("pre_c3",  2, int'(o_cnt[2]), 0);
      if (i == 4)  chk("pre_c4",  2, int'(o_cnt[2]), 1);
      if (i == 8)  chk("pre_c8",  2, int'(o_cnt[2]), 2);
      if (i == 12) chk("pre_c12", 2, int'(o_cnt[2]), 3);
    end

    // Pause mid-prescale: after 6 cycles count 1 with prescaler at 2; resume needs 2 cycles.
    apply(1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) apply(0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 1, 0, 1);
      chk("pause_hold", 2, int'(o_cnt[2]), 1);
    end
    apply(0, 0, 1, 1, 0, 1);
    chk("resume_1", 2, int'(o_cnt[2]), 1);
    apply(0, 0, 1, 1, 0, 1);
    chk("resume_2", 2, int'(o_cnt[2]), 2);

    // Reset while mid-count and mid-prescale: full prescale period needed afterwards.
    apply(0, 1, 1, 0, 8'd200, 1);
    apply(0, 0, 1, 1, 0, 1);
    apply(0, 0, 1, 1, 0, 1);
    apply(1, 0, 1, 1, 0, 1);
    chk("rst_cnt", 2, int'(o_cnt[2]), 0);
    chk("rst_tc",  2, int'(o_tc[2]),  1);
    for (int i = 1; i <= 4; i++) begin
      apply(0, 0, 1, 1, 0, 1);
      chk("rst_repre", 2, int'(o_cnt[2]), (i == 4) ? 1 : 0);
    end

    // MODULO = 2^N on d3: 255 wraps to 0 with a TC pulse.
    apply(0, 1, 1, 0, 8'd255, 1);
    chk("m256_load", 3, int'(o_cnt[3]), 255);
    apply(0, 0, 1, 1, 0, 1);
    chk("m256_wrap", 3, int'(o_cnt[3]), 0);
    chk("m256_tc",   3, int'(o_tc[3]),  0);

    // Randomised traffic, all instances against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r, e, c, l, u;
      logic [7:0] v;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 59) != 0);
      l = ($urandom_range(0, 39) != 0);
      u = ($urandom_range(0, 9) < 6);
      v = 8'($urandom_range(0, 255));
      apply(r, e, c, l, v, u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sc_counter_mod.md
Name: sc_counter_mod

Overview:
Parametrised up/down modulo counter: next generation of the team's basic event counter. Adds programmable modulus, direction control, parallel load, wrap-or-saturate mode, a clock-enable prescaler, a terminal-count pulse and a compare flag. Serves as the general timing/event counter for PWM periods, encoder windows and timeouts in the robot datapath.

Parameters:
N, 8, counter width in bits; count range is 0..MODULO-1.
MODULO, 250, modulus; legal range 2..2^N.
COMPARE, 125, value that asserts the compare flag; legal range 0..MODULO-1.
SATURATE, 0, 0 = wrap at the boundary; 1 = hold at the boundary.
PRESCALE, 1, number of enabled clock cycles per count step; legal range 1..65535.

Ports:
SC_COUNTERMOD_CLOCK  input  1  system clock; all logic on the rising edge.
SC_COUNTERMOD_RESET_InHigh  input  1  synchronous, active-high reset.
SC_COUNTERMOD_ENABLE_InLow  input  1  low = prescaler runs and count may step.
SC_COUNTERMOD_CLEAR_InLow  input  1  low = synchronous clear of count and prescaler.
SC_COUNTERMOD_LOAD_InLow  input  1  low = load SC_COUNTERMOD_LOADVALUE.
SC_COUNTERMOD_LOADVALUE  input  N  parallel load value.
SC_COUNTERMOD_UP  input  1  1 = count up, 0 = count down; sampled at each step.
SC_COUNTERMOD_REGCOUNT  output  N  registered count.
SC_COUNTERMOD_TC_OutLow  output  1  registered terminal-count pulse, low for one cycle.
SC_COUNTERMOD_COMPARE_OutLow  output  1  low while REGCOUNT == COMPARE (combinational from register).

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values: REGCOUNT = 0, prescaler = 0, TC_OutLow = 1. COMPARE_OutLow = 0 if COMPARE == 0, otherwise 1.
- Priority per edge: RESET > CLEAR > LOAD > step > hold.
- CLEAR low: count = 0, prescaler = 0, TC_OutLow = 1. CLEAR dominates a simultaneous LOAD.
- LOAD low: count = LOADVALUE, prescaler = 0, TC_OutLow = 1.
  - If LOADVALUE >= MODULO, the count loads MODULO-1 (clamp).
  - LOAD applies regardless of ENABLE.
- Prescaler:
  - Internal counter of width clog2(PRESCALE), minimum 1 bit.
  - With ENABLE low it increments each cycle. A tick is generated when it equals PRESCALE-1, and the prescaler returns to 0 on the same edge.
  - With ENABLE high the prescaler holds its value.
  - PRESCALE = 1 gives a tick on every enabled cycle.
- Step (on a tick):
  - UP = 1: count+1. If count == MODULO-1: wrap to 0 (SATURATE = 0) or hold MODULO-1 (SATURATE = 1).
  - UP = 0: count-1. If count == 0: wrap to MODULO-1 (SATURATE = 0) or hold 0 (SATURATE = 1).
- Terminal count:
  - TC_OutLow goes low on the edge where a step is taken at the boundary (wrap or saturated hold). It returns high on the next edge unless another boundary step occurs.
  - Saturate mode with ENABLE held low at the boundary produces one TC pulse per tick.
- Latency: REGCOUNT and TC_OutLow update on the same edge that consumes the tick. COMPARE_OutLow follows REGCOUNT with zero added latency.
- Arithmetic: next-count computed at N+1 bits to avoid overflow when MODULO = 2^N.
- Direction change mid-count takes effect on the next tick; no glitch, no extra step.
- Reset mid-count: every register returns to its reset value on that edge. Nothing is carried over.
- Elaboration checks (generate-time $error): MODULO > 2^N, COMPARE >= MODULO, PRESCALE = 0.

Decomposition:
- Shared constants header (sc_counter_defs): direction encodings DIR_UP = 1, DIR_DOWN = 0; mode encodings MODE_WRAP = 0, MODE_SAT = 1; a clog2 function.
- One natural sub-module, sc_prescaler:
  - Parameter PRESCALE.
  - Inputs: clock, synchronous reset, enable_InLow, clear (driven by CLEAR or LOAD).
  - Output: single-cycle tick.
- Top level contains the step/load/clamp logic and the TC/compare outputs.

Test Plan:
- Defaults (N = 8, MODULO = 250, PRESCALE = 1, SATURATE = 0), UP = 1, ENABLE low for 251 cycles after reset: REGCOUNT 0..249 → 0. TC_OutLow low exactly in the cycle REGCOUNT shows 0 after the wrap. COMPARE_OutLow low only while REGCOUNT = 125.
- UP = 0 from reset, ENABLE low for 2 cycles: REGCOUNT 249 then 248. TC pulse on the first edge. SATURATE = 1 variant: REGCOUNT stays 0 and TC pulses every cycle.
- PRESCALE = 4, ENABLE low for 12 cycles: REGCOUNT steps only on cycles 4, 8 and 12 → final value 3. Raise ENABLE after cycle 6: count holds at 1 and the prescaler holds at 2. Lower ENABLE again: next step comes after 2 more cycles.
- LOAD low with LOADVALUE = 100, then LOADVALUE = 255: REGCOUNT = 100, then clamped to 249. CLEAR and LOAD low together: REGCOUNT = 0.
- RESET high for one cycle while REGCOUNT = 200 and the prescaler is mid-count: next edge REGCOUNT = 0, TC_OutLow = 1, and the next step needs a full PRESCALE cycles.
- MODULO = 256, N = 8, UP = 1 from REGCOUNT = 255: wraps to 0 with a TC pulse and no overflow artefact.
